// File: rtl/kcr_stream_sink.sv
// kcr_stream_sink: receiving end of the KCR keystream. Deserialises the serial
// bit stream z into WIDTH-bit words (MSB first), offers them downstream over a
// valid/ready handshake, and reports per-block health statistics (ones count
// and longest run of equal bits) once every BLOCK_LEN accepted bits.
//
// Handshake (word_valid / word_ready): word_valid rises the cycle after a word
// completes, and word/word_valid hold stable until a cycle with
// word_valid && word_ready; word_valid drops the following cycle unless a new
// word completes in that same cycle, in which case the new word is loaded and
// word_valid stays high. A word that completes while word_valid=1 and
// word_ready=0 is dropped, the held word is kept and overflow is set (sticky
// until rst or start).
module kcr_stream_sink #(
    parameter int WIDTH     = 8,
    parameter int BLOCK_LEN = 64,
    parameter int CNT_W     = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             z,
    input  logic             z_valid,
    output logic [WIDTH-1:0] word,
    output logic             word_valid,
    input  logic             word_ready,
    output logic             overflow,
    output logic             busy,
    output logic [CNT_W-1:0] ones_count,
    output logic [CNT_W-1:0] max_run,
    output logic             stat_valid,
    output logic [1:0]       dbg_state
);

    localparam int BC_W = $clog2(BLOCK_LEN + 1);
    localparam int WC_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        REPORT  = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] shreg;
    logic [BC_W-1:0]  bit_cnt;
    logic [WC_W-1:0]  wcnt;
    logic [CNT_W-1:0] ones_acc;
    logic [CNT_W-1:0] run_len;
    logic [CNT_W-1:0] max_acc;
    logic             prev_bit;

    logic             take;
    logic             word_done;
    logic             block_done;
    logic [WIDTH-1:0] shifted;
    logic [CNT_W-1:0] ones_nx;
    logic [CNT_W-1:0] run_nx;
    logic [CNT_W-1:0] max_nx;

    // Bit acceptance and the accumulator values including the incoming bit.
    // A start in COLLECT drops the bit of that cycle.
    always_comb begin
        take       = (state == COLLECT) && z_valid && !start;
        word_done  = take && (wcnt == WC_W'(WIDTH - 1));
        block_done = take && (bit_cnt == BC_W'(BLOCK_LEN - 1));
        shifted    = WIDTH'({shreg, z});
        ones_nx    = ones_acc + CNT_W'(z);
        if ((bit_cnt == '0) || (z != prev_bit)) begin
            run_nx = CNT_W'(1);
        end else if (run_len == '1) begin
            run_nx = run_len;
        end else begin
            run_nx = run_len + CNT_W'(1);
        end
        max_nx = (run_nx > max_acc) ? run_nx : max_acc;
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // FSM next state and state-derived outputs; any start enters COLLECT.
    always_comb begin
        state_nx   = state;
        busy       = 1'b0;
        stat_valid = 1'b0;
        dbg_state  = state;
        case (state)
            IDLE: begin
                if (start) state_nx = COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (start)           state_nx = COLLECT;
                else if (block_done) state_nx = REPORT;
            end
            REPORT: begin
                stat_valid = 1'b1;
                state_nx   = start ? COLLECT : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: shifting, accumulators, statistics capture and word handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            wcnt       <= '0;
            ones_acc   <= '0;
            run_len    <= '0;
            max_acc    <= '0;
            prev_bit   <= 1'b0;
            word       <= '0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
            ones_count <= '0;
            max_run    <= '0;
        end else if (start) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            wcnt       <= '0;
            ones_acc   <= '0;
            run_len    <= '0;
            max_acc    <= '0;
            prev_bit   <= 1'b0;
            word_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (take) begin
                shreg    <= shifted;
                bit_cnt  <= block_done ? '0 : bit_cnt + BC_W'(1);
                wcnt     <= word_done ? '0 : wcnt + WC_W'(1);
                ones_acc <= ones_nx;
                run_len  <= run_nx;
                max_acc  <= max_nx;
                prev_bit <= z;
            end
            if (block_done) begin
                ones_count <= ones_nx;
                max_run    <= max_nx;
            end
            if (word_done) begin
                if (!word_valid || word_ready) begin
                    word       <= shifted;
                    word_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_kcr_stream_sink.sv
// Testbench for kcr_stream_sink: scenario tasks driving random and directed
// keystream blocks, compared against a block-level model of the statistics
// and of the word sequence.
module tb_kcr_stream_sink;

    localparam int WIDTH     = 8;
    localparam int BLOCK_LEN = 64;
    localparam int CNT_W     = 7;
    localparam int NWORDS    = BLOCK_LEN / WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic             z;
    logic             z_valid;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             word_ready;
    logic             overflow;
    logic             busy;
    logic [CNT_W-1:0] ones_count;
    logic [CNT_W-1:0] max_run;
    logic             stat_valid;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] obs_q[$];
    logic [CNT_W-1:0] obs_ones_q[$];
    logic [CNT_W-1:0] obs_run_q[$];
    bit               blk[BLOCK_LEN];

    kcr_stream_sink #(.WIDTH(WIDTH), .BLOCK_LEN(BLOCK_LEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start), .z(z), .z_valid(z_valid),
        .word(word), .word_valid(word_valid), .word_ready(word_ready),
        .overflow(overflow), .busy(busy), .ones_count(ones_count),
        .max_run(max_run), .stat_valid(stat_valid), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- monitor (records, never compares) ----------------
    always @(negedge clk) begin
        if (!rst) begin
            if (word_valid && word_ready) obs_q.push_back(word);
            if (stat_valid) begin
                obs_ones_q.push_back(ones_count);
                obs_run_q.push_back(max_run);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic s, input logic zv, input logic zb);
        start   = s;
        z_valid = zv;
        z       = zb;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_word(input logic [WIDTH-1:0] w);
        for (int k = WIDTH - 1; k >= 0; k--) step(1'b0, 1'b1, w[k]);
    endtask

    task automatic clear_obs();
        obs_q.delete();
        obs_ones_q.delete();
        obs_run_q.delete();
    endtask

    // ---------------- reference model ----------------
    function automatic int model_ones(input bit b[BLOCK_LEN]);
        int n = 0;
        for (int i = 0; i < BLOCK_LEN; i++) n += int'(b[i]);
        return n;
    endfunction

    function automatic int model_max_run(input bit b[BLOCK_LEN]);
        int run  = 0;
        int best = 0;
        for (int i = 0; i < BLOCK_LEN; i++) begin
            if (i == 0 || b[i] != b[i-1]) run = 1;
            else if (run < (1 << CNT_W) - 1) run++;
            if (run > best) best = run;
        end
        return best;
    endfunction

    function automatic logic [WIDTH-1:0] model_word(input bit b[BLOCK_LEN], input int w);
        logic [WIDTH-1:0] r = '0;
        for (int k = 0; k < WIDTH; k++) r[WIDTH-1-k] = b[w*WIDTH + k];
        return r;
    endfunction

    // Start a session, drive blk with the given gap mode (0 none, 1 every
    // third cycle idle, 2 random idles), then compare words and statistics.
    task automatic run_block(input string name, input int gap_mode);
        logic [CNT_W-1:0] e_ones;
        logic [CNT_W-1:0] e_run;
        e_ones = CNT_W'(model_ones(blk));
        e_run  = CNT_W'(model_max_run(blk));
        exp_q.delete();
        for (int w = 0; w < NWORDS; w++) exp_q.push_back(model_word(blk, w));
        word_ready = 1'b1;
        clear_obs();
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %0b expected 1", name, busy);
        end
        for (int i = 0; i < BLOCK_LEN; i++) begin
            if (gap_mode == 1 && i > 0 && i % 2 == 0) step(1'b0, 1'b0, 1'($urandom));
            if (gap_mode == 2) begin
                while ($urandom_range(0, 3) == 0) step(1'b0, 1'b0, 1'($urandom));
            end
            step(1'b0, 1'b1, blk[i]);
        end
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_q.size() != NWORDS) begin
            n_fail++;
            $display("FAIL %s word_count: got %0d expected %0d", name, obs_q.size(), NWORDS);
        end
        for (int w = 0; w < NWORDS && w < obs_q.size(); w++) begin
            n_checks++;
            if (obs_q[w] !== exp_q[w]) begin
                n_fail++;
                $display("FAIL %s word[%0d]: got %h expected %h", name, w, obs_q[w], exp_q[w]);
            end
        end
        n_checks++;
        if (obs_ones_q.size() != 1) begin
            n_fail++;
            $display("FAIL %s stat_pulses: got %0d expected 1", name, obs_ones_q.size());
        end else begin
            n_checks++;
            if (obs_ones_q[0] !== e_ones) begin
                n_fail++;
                $display("FAIL %s ones_count: got %0d expected %0d", name, obs_ones_q[0], e_ones);
            end
            n_checks++;
            if (obs_run_q[0] !== e_run) begin
                n_fail++;
                $display("FAIL %s max_run: got %0d expected %0d", name, obs_run_q[0], e_run);
            end
        end
        n_checks++;
        if (busy !== 1'b0 || word_valid !== 1'b0 || stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s idle_after_block: busy=%0b word_valid=%0b stat_valid=%0b expected 0/0/0",
                     name, busy, word_valid, stat_valid);
        end
        n_checks++;
        if (ones_count !== e_ones || max_run !== e_run) begin
            n_fail++;
            $display("FAIL %s stats_hold: got %0d/%0d expected %0d/%0d",
                     name, ones_count, max_run, e_ones, e_run);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (word !== '0 || word_valid !== 1'b0 || overflow !== 1'b0 || busy !== 1'b0 ||
            ones_count !== '0 || max_run !== '0 || stat_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: word=%h wv=%0b ovf=%0b busy=%0b ones=%0d run=%0d sv=%0b expected all 0",
                     word, word_valid, overflow, busy, ones_count, max_run, stat_valid);
        end
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle_ignores_z: busy=%0b word_valid=%0b expected 0/0", busy, word_valid);
        end
    endtask

    task automatic test_single_word();
        logic [WIDTH-1:0] w = 8'hA5;
        word_ready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int k = WIDTH - 1; k >= 1; k--) step(1'b0, 1'b1, w[k]);
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word_early: word_valid got %0b expected 0", word_valid);
        end
        step(1'b0, 1'b1, w[0]);
        n_checks++;
        if (word_valid !== 1'b1 || word !== w) begin
            n_fail++;
            $display("FAIL single_word_value: word=%h valid=%0b expected %h/1", word, word_valid, w);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL single_word_one_cycle: word_valid got %0b expected 0", word_valid);
        end
    endtask

    task automatic test_gapped_block();
        logic [7:0] plan[8] = '{8'hFF, 8'h00, 8'hF0, 8'h0F, 8'hAA, 8'h55, 8'h00, 8'hFF};
        for (int w = 0; w < 8; w++)
            for (int k = 0; k < 8; k++) blk[w*8 + k] = plan[w][7-k];
        run_block("gapped_block", 1);
        n_checks++;
        if (ones_count !== 7'd32) begin
            n_fail++;
            $display("FAIL gapped_block_ones32: got %0d expected 32", ones_count);
        end
    endtask

    task automatic test_all_ones();
        for (int i = 0; i < BLOCK_LEN; i++) blk[i] = 1'b1;
        run_block("all_ones", 0);
        n_checks++;
        if (ones_count !== 7'd64 || max_run !== 7'd64) begin
            n_fail++;
            $display("FAIL all_ones_const: got %0d/%0d expected 64/64", ones_count, max_run);
        end
    endtask

    task automatic test_random_blocks();
        for (int b = 0; b < 4; b++) begin
            // Bias toward long runs in some blocks to exercise max_run.
            for (int i = 0; i < BLOCK_LEN; i++) begin
                if (b[0] && i > 0 && $urandom_range(0, 9) != 0) blk[i] = blk[i-1];
                else blk[i] = 1'($urandom);
            end
            run_block($sformatf("random_block%0d", b), 2);
        end
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        drive_word(8'h3C);
        drive_word(8'h81);
        n_checks++;
        if (word_valid !== 1'b1 || word !== 8'h3C || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_hold: word=%h valid=%0b ovf=%0b expected 3c/1/1", word, word_valid, overflow);
        end
        clear_obs();
        word_ready = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_q.size() != 1 || obs_q[0] !== 8'h3C) begin
            n_fail++;
            $display("FAIL overflow_accept: got %0d words first %h expected 1 word 3c",
                     obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 8'h00);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_sticky: valid=%0b ovf=%0b expected 0/1", word_valid, overflow);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] wa = WIDTH'($urandom);
        logic [WIDTH-1:0] wb = WIDTH'($urandom);
        word_ready = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (overflow !== 1'b0 || word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL start_clears: ovf=%0b valid=%0b expected 0/0", overflow, word_valid);
        end
        clear_obs();
        drive_word(wa);
        for (int k = WIDTH - 1; k >= 1; k--) step(1'b0, 1'b1, wb[k]);
        word_ready = 1'b1;
        step(1'b0, 1'b1, wb[0]);
        n_checks++;
        if (word_valid !== 1'b1 || word !== wb || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_load: word=%h valid=%0b ovf=%0b expected %h/1/0",
                     word, word_valid, overflow, wb);
        end
        step(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (obs_q.size() != 2 || obs_q[0] !== wa || obs_q[1] !== wb || word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back_order: got %0d words valid=%0b expected %h,%h then valid 0",
                     obs_q.size(), word_valid, wa, wb);
        end
    endtask

    task automatic test_abort();
        word_ready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom));
        for (int i = 0; i < BLOCK_LEN; i++) blk[i] = 1'b0;
        run_block("abort_restart", 0);
    endtask

    task automatic test_start_in_report();
        for (int i = 0; i < BLOCK_LEN; i++) blk[i] = 1'($urandom);
        word_ready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < BLOCK_LEN; i++) step(1'b0, 1'b1, blk[i]);
        n_checks++;
        if (stat_valid !== 1'b1 || word_valid !== 1'b1 || word !== model_word(blk, NWORDS - 1)) begin
            n_fail++;
            $display("FAIL report_with_last_word: sv=%0b wv=%0b word=%h expected 1/1/%h",
                     stat_valid, word_valid, word, model_word(blk, NWORDS - 1));
        end
        step(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (busy !== 1'b1 || stat_valid !== 1'b0 ||
            ones_count !== CNT_W'(model_ones(blk)) || max_run !== CNT_W'(model_max_run(blk))) begin
            n_fail++;
            $display("FAIL start_in_report: busy=%0b sv=%0b ones=%0d run=%0d expected 1/0/%0d/%0d",
                     busy, stat_valid, ones_count, max_run, model_ones(blk), model_max_run(blk));
        end
    endtask

    task automatic test_reset_mid_block();
        word_ready = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) step(1'b0, 1'b1, 1'($urandom));
        clear_obs();
        rst = 1'b1;
        step(1'b0, 1'b1, 1'b1);
        rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || dbg_state !== 2'd0 || word_valid !== 1'b0 || overflow !== 1'b0 ||
            ones_count !== '0 || max_run !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_block: busy=%0b state=%0d wv=%0b ovf=%0b ones=%0d run=%0d expected idle, all 0",
                     busy, dbg_state, word_valid, overflow, ones_count, max_run);
        end
        for (int i = 0; i < 70; i++) step(1'b0, 1'b1, 1'($urandom));
        n_checks++;
        if (obs_ones_q.size() != 0 || obs_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_stat: stat pulses %0d words %0d busy %0b expected 0/0/0",
                     obs_ones_q.size(), obs_q.size(), busy);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        z          = 1'b0;
        z_valid    = 1'b0;
        word_ready = 1'b1;
        test_reset();
        test_single_word();
        test_gapped_block();
        test_all_ones();
        test_random_blocks();
        test_overflow();
        test_back_to_back();
        test_abort();
        test_start_in_report();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
